// File: rtl/t08_lcd_bus_receiver_if.sv
// 8080-style parallel LCD bus as seen by the receiver.
//   bus_data : byte on the bus
//   bus_csx  : chip select, active low
//   bus_wrx  : write strobe, active low (byte taken on the rising edge)
//   bus_rdx  : read strobe, active low (reads are flagged, not served)
//   bus_dcx  : 0 = command byte, 1 = parameter/data byte
interface t08_lcd_bus_receiver_if;
  logic [7:0] bus_data;
  logic       bus_csx;
  logic       bus_wrx;
  logic       bus_rdx;
  logic       bus_dcx;

  modport master (output bus_data, bus_csx, bus_wrx, bus_rdx, bus_dcx);
  modport slave  (input  bus_data, bus_csx, bus_wrx, bus_rdx, bus_dcx);
endinterface

// File: rtl/t08_lcd_bus_receiver.sv
// LCD command/pixel receiver for an asynchronous 8080-style bus.
// Decodes CASET/PASET/RAMWR/DISPON/DISPOFF/NOP/SWRESET and emits one
// RGB565 pixel per two RAMWR data bytes with its target coordinate.
//   clk, rst     : system clock, synchronous active-high reset
//   bus          : bus inputs (slave modport), synchronized internally
//   pixel_valid  : one-cycle pulse qualifying pixel_x/pixel_y/pixel_data
//   display_on   : DISPON/DISPOFF level
//   cmd_error    : sticky, unknown opcode seen
//   rd_seen      : sticky, a read strobe was seen while selected
module t08_lcd_bus_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  t08_lcd_bus_receiver_if.slave        bus,
  output logic                         pixel_valid,
  output logic [15:0]                  pixel_x,
  output logic [15:0]                  pixel_y,
  output logic [15:0]                  pixel_data,
  output logic                         display_on,
  output logic                         cmd_error,
  output logic                         rd_seen
);

  typedef enum logic [2:0] {IDLE, CASET_P, PASET_P, RAMWR_HI, RAMWR_LO} state_t;
  state_t state, state_d;

  // Synchronizers: control lines idle high, data idles at zero.
  logic [SYNC_STAGES-1:0]      csx_sync, wrx_sync, rdx_sync, dcx_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic                        wrx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csx_sync  <= '1;
      wrx_sync  <= '1;
      rdx_sync  <= '1;
      dcx_sync  <= '1;
      data_sync <= '0;
      wrx_q     <= 1'b1;
    end else begin
      csx_sync  <= {csx_sync[SYNC_STAGES-2:0], bus.bus_csx};
      wrx_sync  <= {wrx_sync[SYNC_STAGES-2:0], bus.bus_wrx};
      rdx_sync  <= {rdx_sync[SYNC_STAGES-2:0], bus.bus_rdx};
      dcx_sync  <= {dcx_sync[SYNC_STAGES-2:0], bus.bus_dcx};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.bus_data};
      wrx_q     <= wrx_sync[SYNC_STAGES-1];
    end
  end

  logic       csx_s, wrx_s, rdx_s, dcx_s;
  logic [7:0] data_s;
  assign csx_s  = csx_sync[SYNC_STAGES-1];
  assign wrx_s  = wrx_sync[SYNC_STAGES-1];
  assign rdx_s  = rdx_sync[SYNC_STAGES-1];
  assign dcx_s  = dcx_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Byte accepted on the synchronized rising edge of wrx while selected.
  logic wr_evt, is_cmd, is_par, swreset;
  assign wr_evt  = wrx_s & ~wrx_q & ~csx_s;
  assign is_cmd  = wr_evt & ~dcx_s;
  assign is_par  = wr_evt & dcx_s;
  assign swreset = is_cmd && (data_s == 8'h01);

  // Window, address and parameter collection state.
  logic [15:0] sc, ec, sp, ep, cur_x, cur_y;
  logic [23:0] pbuf;
  logic [1:0]  pcnt;
  logic [7:0]  hi_byte;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (is_cmd) begin
      case (data_s)
        8'h2A:   state_d = CASET_P;
        8'h2B:   state_d = PASET_P;
        8'h2C:   state_d = RAMWR_HI;
        default: state_d = IDLE;
      endcase
    end else if (is_par) begin
      case (state)
        CASET_P, PASET_P: if (pcnt == 2'd3) state_d = IDLE;
        RAMWR_HI:         state_d = RAMWR_LO;
        RAMWR_LO:         state_d = RAMWR_HI;
        default:          state_d = state;
      endcase
    end else if (csx_s && state == RAMWR_LO) begin
      // Deselect drops a half pixel; the pending high byte is simply ignored.
      state_d = RAMWR_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || swreset) begin
      sc          <= 16'd0;
      ec          <= 16'd239;
      sp          <= 16'd0;
      ep          <= 16'd319;
      cur_x       <= 16'd0;
      cur_y       <= 16'd0;
      pbuf        <= '0;
      pcnt        <= '0;
      hi_byte     <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_data  <= '0;
      display_on  <= 1'b0;
      cmd_error   <= 1'b0;
      rd_seen     <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      if (!rdx_s && !csx_s) rd_seen <= 1'b1;
      if (is_cmd) begin
        pcnt <= '0;
        case (data_s)
          8'h2C: begin
            cur_x <= sc;
            cur_y <= sp;
          end
          8'h29:                   display_on <= 1'b1;
          8'h28:                   display_on <= 1'b0;
          8'h2A, 8'h2B, 8'h00: ;
          default:                 cmd_error  <= 1'b1;
        endcase
      end else if (is_par) begin
        case (state)
          CASET_P, PASET_P: begin
            // Bytes 1-3 are buffered; the window commits only on byte 4.
            pbuf <= {pbuf[15:0], data_s};
            pcnt <= pcnt + 2'd1;
            if (pcnt == 2'd3) begin
              if (state == CASET_P) begin
                sc <= pbuf[23:8];
                ec <= {pbuf[7:0], data_s};
              end else begin
                sp <= pbuf[23:8];
                ep <= {pbuf[7:0], data_s};
              end
            end
          end
          RAMWR_HI: hi_byte <= data_s;
          RAMWR_LO: begin
            pixel_valid <= 1'b1;
            pixel_x     <= cur_x;
            pixel_y     <= cur_y;
            pixel_data  <= {hi_byte, data_s};
            // Equality-only compare gives 16-bit wrap when start > end.
            if (cur_x == ec) begin
              cur_x <= sc;
              cur_y <= (cur_y == ep) ? sp : cur_y + 16'd1;
            end else begin
              cur_x <= cur_x + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t08_lcd_bus_receiver.sv
module tb_t08_lcd_bus_receiver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_valid, display_on, cmd_error, rd_seen;
  logic [15:0] pixel_x, pixel_y, pixel_data;
  int          checks = 0;
  int          errors = 0;
  logic [47:0] pix_q[$];

  t08_lcd_bus_receiver_if bif();

  t08_lcd_bus_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bif),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .display_on(display_on),
    .cmd_error(cmd_error), .rd_seen(rd_seen)
  );

  always #5 clk = ~clk;

  // Collect every emitted pixel as {x, y, data}.
  always @(negedge clk) if (pixel_valid === 1'b1) pix_q.push_back({pixel_x, pixel_y, pixel_data});

  function automatic logic [47:0] pix_at(input int k);
    if (k < pix_q.size()) return pix_q[k];
    return 48'hxxxx_xxxx_xxxx;
  endfunction

  task automatic wr(input logic dc, input logic [7:0] d);
    bif.bus_dcx  = dc;
    bif.bus_data = d;
    bif.bus_wrx  = 1'b0;
    repeat (3) @(negedge clk);
    bif.bus_wrx  = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic px(input logic [15:0] v);
    wr(1'b1, v[15:8]);
    wr(1'b1, v[7:0]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    bif.bus_csx = 1'b1; bif.bus_wrx = 1'b1; bif.bus_rdx = 1'b1;
    bif.bus_dcx = 1'b1; bif.bus_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bif.bus_csx = 1'b0;
    @(negedge clk);
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pixel_valid); end
    checks++; if (pixel_x !== 16'd0) begin errors++; $display("FAIL reset_x got=%h exp=0", pixel_x); end
    checks++; if (pixel_y !== 16'd0) begin errors++; $display("FAIL reset_y got=%h exp=0", pixel_y); end
    checks++; if (pixel_data !== 16'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", pixel_data); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL reset_dispon got=%b exp=0", display_on); end
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL reset_cmderr got=%b exp=0", cmd_error); end
    checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL reset_rdseen got=%b exp=0", rd_seen); end
  endtask

  task automatic test_window_pixels();
    logic [47:0] exp [4];
    exp[0] = {16'd10, 16'd5, 16'hF800};
    exp[1] = {16'd11, 16'd5, 16'h07E0};
    exp[2] = {16'd10, 16'd6, 16'h001F};
    exp[3] = {16'd11, 16'd6, 16'hFFFF};
    pix_q.delete();
    wr(1'b0, 8'h2A); wr(1'b1, 8'h00); wr(1'b1, 8'h0A); wr(1'b1, 8'h00); wr(1'b1, 8'h0B);
    wr(1'b0, 8'h2B); wr(1'b1, 8'h00); wr(1'b1, 8'h05); wr(1'b1, 8'h00); wr(1'b1, 8'h06);
    wr(1'b0, 8'h2C);
    px(16'hF800); px(16'h07E0); px(16'h001F); px(16'hFFFF);
    settle();
    checks++; if (pix_q.size() != 4) begin errors++; $display("FAIL window_count got=%0d exp=4", pix_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix_at(i) !== exp[i]) begin
        errors++; $display("FAIL window_pix%0d got=%h exp=%h", i, pix_at(i), exp[i]);
      end
    end
  endtask

  task automatic test_csx_abort();
    pix_q.delete();
    wr(1'b0, 8'h2C);
    wr(1'b1, 8'hAB);
    bif.bus_csx = 1'b1;
    repeat (4) @(negedge clk);
    bif.bus_csx = 1'b0;
    repeat (4) @(negedge clk);
    wr(1'b1, 8'h12); wr(1'b1, 8'h34);
    settle();
    checks++; if (pix_q.size() != 1) begin errors++; $display("FAIL csx_count got=%0d exp=1", pix_q.size()); end
    checks++;
    if (pix_at(0) !== {16'd10, 16'd5, 16'h1234}) begin
      errors++; $display("FAIL csx_pix got=%h exp=%h", pix_at(0), {16'd10, 16'd5, 16'h1234});
    end
  endtask

  task automatic test_cmd_error_swreset();
    wr(1'b0, 8'h55); wr(1'b0, 8'h29);
    settle();
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL cmderr_set got=%b exp=1", cmd_error); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL dispon_set got=%b exp=1", display_on); end
    wr(1'b0, 8'h01);
    settle();
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL cmderr_swrst got=%b exp=0", cmd_error); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL dispon_swrst got=%b exp=0", display_on); end
    // Default window again: 240 pixels per row starting at (0,0).
    pix_q.delete();
    wr(1'b0, 8'h2C);
    for (int i = 0; i < 241; i++) px(16'(i));
    settle();
    checks++; if (pix_q.size() != 241) begin errors++; $display("FAIL default_count got=%0d exp=241", pix_q.size()); end
    checks++; if (pix_at(0) !== {16'd0, 16'd0, 16'd0}) begin errors++; $display("FAIL default_pix1 got=%h exp=%h", pix_at(0), {16'd0, 16'd0, 16'd0}); end
    checks++; if (pix_at(239) !== {16'd239, 16'd0, 16'd239}) begin errors++; $display("FAIL default_pix240 got=%h exp=%h", pix_at(239), {16'd239, 16'd0, 16'd239}); end
    checks++; if (pix_at(240) !== {16'd0, 16'd1, 16'd240}) begin errors++; $display("FAIL default_pix241 got=%h exp=%h", pix_at(240), {16'd0, 16'd1, 16'd240}); end
  endtask

  task automatic test_ep_wrap();
    pix_q.delete();
    wr(1'b0, 8'h2B); wr(1'b1, 8'h00); wr(1'b1, 8'h00); wr(1'b1, 8'h00); wr(1'b1, 8'h01);
    wr(1'b0, 8'h2C);
    for (int i = 0; i < 481; i++) px(16'(i));
    settle();
    checks++; if (pix_q.size() != 481) begin errors++; $display("FAIL epwrap_count got=%0d exp=481", pix_q.size()); end
    checks++; if (pix_at(240) !== {16'd0, 16'd1, 16'd240}) begin errors++; $display("FAIL epwrap_pix241 got=%h exp=%h", pix_at(240), {16'd0, 16'd1, 16'd240}); end
    checks++; if (pix_at(480) !== {16'd0, 16'd0, 16'd480}) begin errors++; $display("FAIL epwrap_pix481 got=%h exp=%h", pix_at(480), {16'd0, 16'd0, 16'd480}); end
  endtask

  task automatic test_partial_caset_rd();
    logic [47:0] exp [3];
    exp[0] = {16'd10, 16'd0, 16'hA001};
    exp[1] = {16'd11, 16'd0, 16'hA002};
    exp[2] = {16'd10, 16'd1, 16'hA003};
    pix_q.delete();
    wr(1'b0, 8'h2A); wr(1'b1, 8'h00); wr(1'b1, 8'h0A); wr(1'b1, 8'h00); wr(1'b1, 8'h0B);
    wr(1'b0, 8'h2A); wr(1'b1, 8'h00); wr(1'b1, 8'h20);
    wr(1'b0, 8'h2C);
    px(16'hA001); px(16'hA002); px(16'hA003);
    settle();
    checks++; if (pix_q.size() != 3) begin errors++; $display("FAIL partial_count got=%0d exp=3", pix_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_at(i) !== exp[i]) begin
        errors++; $display("FAIL partial_pix%0d got=%h exp=%h", i, pix_at(i), exp[i]);
      end
    end
    checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL rdseen_before got=%b exp=0", rd_seen); end
    bif.bus_rdx = 1'b0;
    repeat (4) @(negedge clk);
    bif.bus_rdx = 1'b1;
    settle();
    checks++; if (rd_seen !== 1'b1) begin errors++; $display("FAIL rdseen_after got=%b exp=1", rd_seen); end
  endtask

  task automatic test_reset_mid_pixel();
    pix_q.delete();
    wr(1'b0, 8'h2C);
    wr(1'b1, 8'hEE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    settle();
    checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL midrst_rdseen got=%b exp=0", rd_seen); end
    wr(1'b0, 8'h2C);
    wr(1'b1, 8'h56); wr(1'b1, 8'h78);
    settle();
    checks++; if (pix_q.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", pix_q.size()); end
    checks++; if (pix_at(0) !== {16'd0, 16'd0, 16'h5678}) begin errors++; $display("FAIL midrst_pix got=%h exp=%h", pix_at(0), {16'd0, 16'd0, 16'h5678}); end
  endtask

  initial begin
    test_reset();
    test_window_pixels();
    test_csx_abort();
    test_cmd_error_swreset();
    test_ep_wrap();
    test_partial_caset_rd();
    test_reset_mid_pixel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t08_lcd_bus_receiver.md
T08_LCD_BUS_RECEIVER -- requirements
Module: t08_lcd_bus_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: depth of the input synchronizer chain on every bus input; legal values 2-3.
REQ-002 Port: clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 Port: rst, input, 1, reset, synchronous and active-high.
REQ-004 Port: bus_data, input, 8, parallel 8080-style bus byte (driven by t08_top spi_outputs).
REQ-005 Port: bus_csx, bus_wrx, bus_rdx, bus_dcx, input, 1 each, active-low chip select, write strobe, read strobe, and data/command select (0 = command, 1 = parameter/data).
REQ-006 Port: pixel_valid, output, 1, one-cycle pulse; pixel_x, pixel_y, pixel_data are valid in that cycle.
REQ-007 Port: pixel_x, pixel_y, output, 16 each, target coordinate of the current pixel.
REQ-008 Port: pixel_data, output, 16, RGB565 pixel value (first byte = bits 15:8).
REQ-009 Port: display_on, output, 1, level; set by DISPON and cleared by DISPOFF or SWRESET.
REQ-010 Port: cmd_error, output, 1, sticky; set on an unknown command opcode, cleared only by rst or SWRESET.
REQ-011 Port: rd_seen, output, 1, sticky; set when synchronized bus_rdx is low while bus_csx is low (reads are not supported).

Function
REQ-012 Each bus input shall pass through a SYNC_STAGES-flop synchronizer; all decoding uses synchronized values only.
REQ-013 A write event is a cycle in which synchronized wrx = 1, its prior-cycle value = 0, and synchronized csx = 0; data and dcx are taken from the same synchronized stage in that cycle.
REQ-014 The FSM states shall be IDLE, CASET_P, PASET_P, RAMWR_HI, RAMWR_LO.
REQ-015 A command byte (dcx = 0) in any state shall abort the current state and decode the opcode: 0x2A -> CASET_P, 0x2B -> PASET_P, 0x2C -> RAMWR_HI with (cur_x, cur_y) = (SC, SP), 0x29 -> display_on = 1, 0x28 -> display_on = 0, 0x00 (NOP) -> IDLE, 0x01 -> SWRESET, any other value -> cmd_error = 1 and IDLE.
REQ-016 CASET_P and PASET_P shall accept exactly 4 parameter bytes (start hi, start lo, end hi, end lo) into SC/EC or SP/EP, then go to IDLE; extra parameter bytes in IDLE are ignored.
REQ-017 A partially received CASET or PASET parameter set shall leave the previous SC/EC or SP/EP unchanged; the new values are committed only on the 4th byte.
REQ-018 In RAMWR_HI, a data byte shall be latched as the high byte and the state moves to RAMWR_LO; in RAMWR_LO, a data byte shall complete the pixel and the state returns to RAMWR_HI.
REQ-019 Latency: pixel_valid shall pulse in the cycle after the RAMWR_LO write event, with pixel_x = cur_x and pixel_y = cur_y prior to the address advance.
REQ-020 Address advance: if cur_x == EC then cur_x = SC and cur_y advances; otherwise cur_x + 1 (16-bit). The y advance is: if cur_y == EP then cur_y = SP; otherwise cur_y + 1.
REQ-021 If SC > EC, x shall increment with 16-bit wrap until it equals EC; the same rule applies to y.
REQ-022 When synchronized csx goes high, a pending high byte shall be discarded and the state returns from RAMWR_LO to RAMWR_HI; all other state is kept.
REQ-023 SWRESET shall apply the REQ-024 values to all registers except the synchronizers.

Reset
REQ-024 While rst = 1 at a clock edge, the following values shall apply: state = IDLE; SC = SP = 0; EC = 239; EP = 319; cur_x = cur_y = 0; all outputs = 0; synchronizer flops = 1 (bus idle-high), bus_data flops = 0.
REQ-025 Reset asserted mid-pixel or mid-parameter shall discard all partial data, and no pixel_valid shall occur for it.

Verification
REQ-026 The bench shall cover CASET 0x2A [00 0A 00 0B], PASET 0x2B [00 05 00 06], RAMWR, and 4 pixels F800, 07E0, 001F, FFFF -> pixel_valid x4 at (10,5), (11,5), (10,6), (11,6) with the matching data.
REQ-027 The bench shall cover RAMWR with default window and 241 pixels -> the 241st pixel is at (0,1); with EP = 1, pixel 481 wraps to (0,0).
REQ-028 The bench shall cover RAMWR, byte 0xAB, csx high for 4 clocks, csx low, bytes 0x12 0x34 -> exactly one pixel 0x1234 at (SC,SP).
REQ-029 The bench shall cover command 0x55 then 0x29 -> cmd_error = 1 and display_on = 1; command 0x01 -> both 0 and window back to 0..239 x 0..319.
REQ-030 The bench shall cover CASET with only 2 params, then RAMWR -> the old SC/EC is in use; rdx low with csx low -> rd_seen = 1.
REQ-031 The bench shall cover rst pulse (1 cycle) between high and low byte -> no pixel_valid, and the next 2 bytes after a new RAMWR give one pixel at (0,0).
